// File: rtl/base_hit_arbiter_pkg.sv
// Shared types and defaults for the base hit arbiter: FSM states, winner
// encodings and the HP limits used at game start and for healing.
package base_hit_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HURT = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    localparam int HP_W        = 3;
    localparam int HP_INIT_DEF = 5;
    localparam int HP_CAP_DEF  = 6;

endpackage

// File: rtl/base_hit_arbiter_if.sv
// Game-side bundle of the arbiter: cannonball hit requests, power-up heals,
// acknowledges back to the balls and the base status seen by the display.
interface base_hit_arbiter_if
    import base_hit_arbiter_pkg::*;
();

    logic            before_game_flag;
    logic            hit_req1;
    logic            hit_req2;
    logic            heal_req1;
    logic            heal_req2;
    logic            ack1;
    logic            ack2;
    logic [HP_W-1:0] base1_HP;
    logic [HP_W-1:0] base2_HP;
    logic            base1_ruin;
    logic            base2_ruin;
    logic            game_over;
    logic [1:0]      winner;

    modport master (
        output before_game_flag, hit_req1, hit_req2, heal_req1, heal_req2,
        input  ack1, ack2, base1_HP, base2_HP, base1_ruin, base2_ruin,
               game_over, winner
    );

    modport slave (
        input  before_game_flag, hit_req1, hit_req2, heal_req1, heal_req2,
        output ack1, ack2, base1_HP, base2_HP, base1_ruin, base2_ruin,
               game_over, winner
    );

endinterface

// File: rtl/hurt_timer.sv
// Clearable counter that climbs to HURT_CYCLES-1 and sticks there; o_done
// marks that the minimum acknowledge time has elapsed.
module hurt_timer #(
    parameter int HURT_CYCLES = 33554432
) (
    input  logic Clk,
    input  logic Reset,
    input  logic i_clr,
    output logic o_done
);

    localparam int CW = (HURT_CYCLES > 1) ? $clog2(HURT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(HURT_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge Clk) begin
        if (Reset || i_clr) begin
            r_cnt <= '0;
        end else if (r_cnt != LAST) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_done = (r_cnt == LAST);

endmodule

// File: rtl/base_hit_arbiter.sv
// Arbitrates cannonball hits on the two bases, applies one-shot heals and
// declares the winner once a base's HP reaches zero.
module base_hit_arbiter
    import base_hit_arbiter_pkg::*;
#(
    parameter int HURT_CYCLES = 33554432,
    parameter int HP_INIT     = HP_INIT_DEF,
    parameter int HP_CAP      = HP_CAP_DEF
) (
    input logic               Clk,
    input logic               Reset,
    base_hit_arbiter_if.slave bus
);

    localparam logic [HP_W-1:0] HP_INIT_V = HP_W'(HP_INIT);
    localparam logic [HP_W-1:0] HP_CAP_V  = HP_W'(HP_CAP);

    state_t          r_state;
    logic            r_owner2;
    logic            r_last2;
    logic [HP_W-1:0] r_hp1;
    logic [HP_W-1:0] r_hp2;
    logic            r_healed1;
    logic            r_healed2;
    logic            r_ack1;
    logic            r_ack2;
    logic [1:0]      r_winner;

    logic            w_rst;
    logic            w_done;
    logic            w_grant1;
    logic            w_grant2;
    logic            w_heal1;
    logic            w_heal2;
    logic            w_own_req;
    logic [HP_W-1:0] w_tgt_hp;

    assign w_rst = Reset | bus.before_game_flag;

    hurt_timer #(
        .HURT_CYCLES(HURT_CYCLES)
    ) u_hurt_timer (
        .Clk   (Clk),
        .Reset (w_rst),
        .i_clr (r_state != ST_HURT),
        .o_done(w_done)
    );

    // On a tie the ball not served last wins; r_last2 = 1 means ball2 was last.
    assign w_grant1 = (r_state == ST_IDLE) && bus.hit_req1 && (!bus.hit_req2 || r_last2);
    assign w_grant2 = (r_state == ST_IDLE) && bus.hit_req2 && (!bus.hit_req1 || !r_last2);

    assign w_heal1 = bus.heal_req1 && !r_healed1 && (r_hp1 != '0) && (r_hp1 < HP_CAP_V);
    assign w_heal2 = bus.heal_req2 && !r_healed2 && (r_hp2 != '0) && (r_hp2 < HP_CAP_V);

    // Ball1 damages base2 and ball2 damages base1.
    assign w_own_req = r_owner2 ? bus.hit_req2 : bus.hit_req1;
    assign w_tgt_hp  = r_owner2 ? r_hp1 : r_hp2;

    always_ff @(posedge Clk) begin
        if (w_rst) begin
            r_state   <= ST_IDLE;
            r_owner2  <= 1'b0;
            r_last2   <= 1'b1;
            r_hp1     <= HP_INIT_V;
            r_hp2     <= HP_INIT_V;
            r_healed1 <= 1'b0;
            r_healed2 <= 1'b0;
            r_ack1    <= 1'b0;
            r_ack2    <= 1'b0;
            r_winner  <= WIN_NONE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant1) begin
                        r_hp2    <= r_hp2 - 1'b1;
                        r_owner2 <= 1'b0;
                        r_last2  <= 1'b0;
                        r_ack1   <= 1'b1;
                        r_state  <= ST_HURT;
                    end else if (w_grant2) begin
                        r_hp1    <= r_hp1 - 1'b1;
                        r_owner2 <= 1'b1;
                        r_last2  <= 1'b1;
                        r_ack2   <= 1'b1;
                        r_state  <= ST_HURT;
                    end else begin
                        if (w_heal1) begin
                            r_hp1     <= r_hp1 + 1'b1;
                            r_healed1 <= 1'b1;
                        end
                        if (w_heal2) begin
                            r_hp2     <= r_hp2 + 1'b1;
                            r_healed2 <= 1'b1;
                        end
                    end
                end
                ST_HURT: begin
                    if (w_done && !w_own_req) begin
                        r_ack1 <= 1'b0;
                        r_ack2 <= 1'b0;
                        if (w_tgt_hp == '0) begin
                            r_state  <= ST_OVER;
                            r_winner <= r_owner2 ? WIN_P2 : WIN_P1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_OVER: begin
                    r_ack1 <= 1'b0;
                    r_ack2 <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ack1  <= 1'b0;
                    r_ack2  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack1       = r_ack1;
    assign bus.ack2       = r_ack2;
    assign bus.base1_HP   = r_hp1;
    assign bus.base2_HP   = r_hp2;
    assign bus.base1_ruin = (r_hp1 == '0);
    assign bus.base2_ruin = (r_hp2 == '0);
    assign bus.game_over  = (r_state == ST_OVER);
    assign bus.winner     = r_winner;

endmodule
